// File: rtl/universal_shift_register.sv
// universal_shift_register: N-bit shift/rotate register with single-step modes and counted burst shifts
module universal_shift_register #(
  parameter int N = 8
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Enable,
  input  logic                   Load,
  input  logic [N-1:0]           DataIn,
  input  logic [2:0]             Mode,
  input  logic                   LeftInput,
  input  logic                   RightInput,
  input  logic                   Start,
  output logic [N-1:0]           Result,
  output logic                   SerialOut,
  output logic                   Busy,
  output logic                   Done,
  output logic [$clog2(N+1)-1:0] Count
);
  localparam int CW = $clog2(N+1);
  logic dir;
  logic step, start, single, so_nxt;
  logic [N-1:0] shl, shr, nxt;
  always_comb begin
    step = Busy && Enable;
    start = !Busy && Start && Mode[2:1] == 2'b11;
    single = Enable && Mode != 3'b000 && Mode[2:1] != 2'b11;
    shl = {Result[N-2:0], RightInput};
    shr = {LeftInput, Result[N-1:1]};
    nxt = Mode == 3'b001 ? shl :
          Mode == 3'b010 ? shr :
          Mode == 3'b011 ? {Result[N-2:0], Result[N-1]} :
          Mode == 3'b100 ? {Result[0], Result[N-1:1]} :
                           {Result[N-1], Result[N-1:1]};
    so_nxt = (Mode == 3'b001 || Mode == 3'b011) ? Result[N-1] : Result[0];
  end
  always_ff @(posedge Clock) begin
    Done <= 1'b0;
    if (!Reset) begin
      Result <= '0;
      SerialOut <= 1'b0;
      Busy <= 1'b0;
      Count <= '0;
      dir <= 1'b0;
    end else if (Load) begin
      Result <= DataIn;
      Busy <= 1'b0;
      Count <= '0;
    end else if (step) begin
      Result <= dir ? shr : shl;
      SerialOut <= dir ? Result[0] : Result[N-1];
      Count <= Count - CW'(1);
      if (Count == CW'(1)) begin
        Busy <= 1'b0;
        Done <= 1'b1;
      end
    end else if (start) begin
      Busy <= 1'b1;
      Count <= CW'(N);
      dir <= Mode[0];
    end else if (single) begin
      Result <= nxt;
      SerialOut <= so_nxt;
    end
  end
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed vectors with a queue-based scoreboard checked after every edge
module tb_universal_shift_register;
  logic clk = 1'b0;
  logic rst, en, ld, st, li, ri;
  logic [2:0] mode;
  logic [7:0] din;
  logic [7:0] result;
  logic serial_out, busy, done;
  logic [3:0] count;
  typedef struct {
    string tag;
    logic [7:0] r;
    logic so, b, d;
    logic [3:0] c;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int checks = 0;
  int errors = 0;
  universal_shift_register #(.N(8)) dut (
    .Clock(clk), .Reset(rst), .Enable(en), .Load(ld), .DataIn(din), .Mode(mode),
    .LeftInput(li), .RightInput(ri), .Start(st), .Result(result), .SerialOut(serial_out),
    .Busy(busy), .Done(done), .Count(count)
  );
  always #5 clk = ~clk;
  task automatic cyc(input string tag, input logic rst_i, ld_i, en_i, st_i, input logic [2:0] mode_i,
                     input logic li_i, ri_i, input logic [7:0] din_i, input logic [7:0] r,
                     input logic so, b, d, input logic [3:0] c);
    exp_t e;
    @(negedge clk);
    rst = rst_i; ld = ld_i; en = en_i; st = st_i; mode = mode_i; li = li_i; ri = ri_i; din = din_i;
    e.tag = tag; e.r = r; e.so = so; e.b = b; e.d = d; e.c = c;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      checks++;
      if ({result, serial_out, busy, done, count} !== {m.r, m.so, m.b, m.d, m.c}) begin
        errors++;
        $display("FAIL %s: got R=%h so=%b busy=%b done=%b cnt=%0d, want R=%h so=%b busy=%b done=%b cnt=%0d",
                 m.tag, result, serial_out, busy, done, count, m.r, m.so, m.b, m.d, m.c);
      end
    end
  end
  initial begin
    rst = 1'b1; ld = 1'b0; en = 1'b0; st = 1'b0; mode = 3'b000; li = 1'b0; ri = 1'b0; din = 8'h00;
    //   tag                 rst ld en st mode    li ri din     R      so b  d  cnt
    cyc("reset",             0, 1, 1, 0, 3'b001, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 0);
    cyc("load96",            1, 1, 0, 0, 3'b000, 0, 0, 8'h96, 8'h96, 0, 0, 0, 0);
    cyc("asr",               1, 0, 1, 0, 3'b101, 0, 0, 8'h00, 8'hCB, 0, 0, 0, 0);
    cyc("rol",               1, 0, 1, 0, 3'b011, 0, 0, 8'h00, 8'h97, 1, 0, 0, 0);
    cyc("shl",               1, 0, 1, 0, 3'b001, 0, 0, 8'h00, 8'h2E, 1, 0, 0, 0);
    cyc("shr",               1, 0, 1, 0, 3'b010, 1, 0, 8'h00, 8'h97, 0, 0, 0, 0);
    cyc("ror",               1, 0, 1, 0, 3'b100, 0, 0, 8'h00, 8'hCB, 1, 0, 0, 0);
    cyc("mode0_hold",        1, 0, 1, 0, 3'b000, 0, 0, 8'h00, 8'hCB, 1, 0, 0, 0);
    cyc("en0_hold",          1, 0, 0, 0, 3'b001, 0, 0, 8'h00, 8'hCB, 1, 0, 0, 0);
    cyc("start_bad_mode",    1, 0, 0, 1, 3'b101, 0, 0, 8'h00, 8'hCB, 1, 0, 0, 0);
    cyc("start_with_load",   1, 1, 0, 1, 3'b110, 0, 0, 8'hA5, 8'hA5, 1, 0, 0, 0);
    cyc("burst_l_start",     1, 0, 1, 1, 3'b110, 0, 0, 8'h00, 8'hA5, 1, 1, 0, 8);
    cyc("burst_l_s1",        1, 0, 1, 1, 3'b010, 1, 0, 8'h00, 8'h4A, 1, 1, 0, 7);
    cyc("burst_l_s2",        1, 0, 1, 0, 3'b010, 1, 0, 8'h00, 8'h94, 0, 1, 0, 6);
    cyc("burst_l_s3",        1, 0, 1, 1, 3'b111, 1, 0, 8'h00, 8'h28, 1, 1, 0, 5);
    cyc("burst_l_s4",        1, 0, 1, 0, 3'b000, 0, 0, 8'h00, 8'h50, 0, 1, 0, 4);
    cyc("burst_l_s5",        1, 0, 1, 0, 3'b100, 0, 0, 8'h00, 8'hA0, 0, 1, 0, 3);
    cyc("burst_l_s6",        1, 0, 1, 0, 3'b101, 0, 0, 8'h00, 8'h40, 1, 1, 0, 2);
    cyc("burst_l_s7",        1, 0, 1, 0, 3'b001, 0, 0, 8'h00, 8'h80, 0, 1, 0, 1);
    cyc("burst_l_s8",        1, 0, 1, 0, 3'b001, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0);
    cyc("done_clear",        1, 0, 0, 0, 3'b000, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    cyc("load81",            1, 1, 0, 0, 3'b000, 0, 0, 8'h81, 8'h81, 1, 0, 0, 0);
    cyc("burst_r_start",     1, 0, 0, 1, 3'b111, 1, 0, 8'h00, 8'h81, 1, 1, 0, 8);
    cyc("burst_r_stall1",    1, 0, 0, 1, 3'b110, 1, 0, 8'h00, 8'h81, 1, 1, 0, 8);
    cyc("burst_r_s1",        1, 0, 1, 0, 3'b000, 1, 0, 8'h00, 8'hC0, 1, 1, 0, 7);
    cyc("burst_r_stall2",    1, 0, 0, 0, 3'b000, 1, 0, 8'h00, 8'hC0, 1, 1, 0, 7);
    cyc("burst_r_s2",        1, 0, 1, 0, 3'b000, 1, 0, 8'h00, 8'hE0, 0, 1, 0, 6);
    cyc("burst_r_stall3",    1, 0, 0, 0, 3'b000, 1, 0, 8'h00, 8'hE0, 0, 1, 0, 6);
    cyc("burst_r_s3",        1, 0, 1, 0, 3'b000, 1, 0, 8'h00, 8'hF0, 0, 1, 0, 5);
    cyc("burst_r_stall4",    1, 0, 0, 0, 3'b000, 1, 0, 8'h00, 8'hF0, 0, 1, 0, 5);
    cyc("burst_r_s4",        1, 0, 1, 0, 3'b000, 1, 0, 8'h00, 8'hF8, 0, 1, 0, 4);
    cyc("burst_r_stall5",    1, 0, 0, 0, 3'b000, 1, 0, 8'h00, 8'hF8, 0, 1, 0, 4);
    cyc("burst_r_s5",        1, 0, 1, 0, 3'b000, 1, 0, 8'h00, 8'hFC, 0, 1, 0, 3);
    cyc("burst_r_stall6",    1, 0, 0, 0, 3'b000, 1, 0, 8'h00, 8'hFC, 0, 1, 0, 3);
    cyc("burst_r_s6",        1, 0, 1, 0, 3'b000, 1, 0, 8'h00, 8'hFE, 0, 1, 0, 2);
    cyc("burst_r_stall7",    1, 0, 0, 0, 3'b000, 1, 0, 8'h00, 8'hFE, 0, 1, 0, 2);
    cyc("burst_r_s7",        1, 0, 1, 0, 3'b000, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 1);
    cyc("burst_r_stall8",    1, 0, 0, 0, 3'b000, 1, 0, 8'h00, 8'hFF, 0, 1, 0, 1);
    cyc("burst_r_s8",        1, 0, 1, 0, 3'b000, 1, 0, 8'h00, 8'hFF, 1, 0, 1, 0);
    cyc("b2b_start",         1, 0, 1, 1, 3'b110, 0, 1, 8'h00, 8'hFF, 1, 1, 0, 8);
    cyc("b2b_s1",            1, 0, 1, 0, 3'b000, 0, 1, 8'h00, 8'hFF, 1, 1, 0, 7);
    cyc("b2b_s2",            1, 0, 1, 0, 3'b000, 0, 1, 8'h00, 8'hFF, 1, 1, 0, 6);
    cyc("b2b_s3",            1, 0, 1, 0, 3'b000, 0, 1, 8'h00, 8'hFF, 1, 1, 0, 5);
    cyc("abort_load",        1, 1, 1, 0, 3'b000, 0, 1, 8'h3C, 8'h3C, 1, 0, 0, 0);
    cyc("abort_idle1",       1, 0, 1, 0, 3'b000, 0, 0, 8'h00, 8'h3C, 1, 0, 0, 0);
    cyc("abort_idle2",       1, 0, 0, 0, 3'b000, 0, 0, 8'h00, 8'h3C, 1, 0, 0, 0);
    cyc("abort_idle3",       1, 0, 0, 0, 3'b000, 0, 0, 8'h00, 8'h3C, 1, 0, 0, 0);
    cyc("burst_r2_start",    1, 0, 0, 1, 3'b111, 0, 0, 8'h00, 8'h3C, 1, 1, 0, 8);
    cyc("burst_r2_s1",       1, 0, 1, 0, 3'b000, 0, 0, 8'h00, 8'h1E, 0, 1, 0, 7);
    cyc("reset_mid_burst",   0, 0, 1, 0, 3'b000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    cyc("post_reset1",       1, 0, 0, 0, 3'b000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    cyc("post_reset2",       1, 0, 0, 0, 3'b000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left in queue, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
